// File: rtl/ps2_pkg.sv
// Shared constants and decoder state type for the PS/2 scancode receiver.
package ps2_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam int         FRAME_BITS = 11;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_BRK,
    DEC_EXT,
    DEC_EXT_BRK
  } dec_state_t;

  // Data bits plus parity bit must carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_scan_rx_if.sv
// Key-event output bundle from the PS/2 receiver to the scancode RAM stage.
interface ps2_scan_rx_if;

  logic       key_we;
  logic [7:0] key_addr;
  logic [7:0] key_code;
  logic       key_down;
  logic       overflow;

  modport master (
    output key_we,
    output key_addr,
    output key_code,
    output key_down,
    output overflow
  );

  modport slave (
    input key_we,
    input key_addr,
    input key_code,
    input key_down,
    input overflow
  );

endinterface

// File: rtl/ps2_fifo.sv
// Small synchronous FIFO for received scancodes; head shows the oldest entry.
module ps2_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: frame capture, scancode FIFO and make/break decoder.
// Define PS2_PARITY_CHECK_EN to also reject frames with bad odd parity.
//
// state       | meaning
// DEC_IDLE    | waiting for a make, F0 or E0 prefix
// DEC_BRK     | F0 seen; next code is a release
// DEC_EXT     | E0 seen; next code is an extended make or F0
// DEC_EXT_BRK | E0 F0 seen; next code is an extended release
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] TIMEOUT_CYC = 16'd5000
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_scan_rx_if.master kif
);

  logic [2:0]            clk_sync;
  logic [1:0]            data_sync;
  logic                  fall;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] frame;
  logic [FRAME_BITS-1:0] frame_nxt;
  logic [15:0]           to_cnt;
  logic                  frame_end;
  logic                  frame_ok;
  logic                  timeout;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [7:0]            fifo_head;

  dec_state_t            state_q;
  dec_state_t            state_d;
  logic                  make_evt;
  logic                  brk_evt;
  logic                  key_we_q;
  logic [7:0]            key_addr_q;
  logic [7:0]            key_code_q;
  logic                  key_down_q;
  logic [7:0]            last_code_q;
  logic                  overflow_q;

  assign fall      = (clk_sync[2:1] == 2'b10);
  assign frame_end = fall && (bit_cnt == 4'(FRAME_BITS - 1));
  assign timeout   = !fall && (bit_cnt != 4'd0) && (to_cnt == 16'd0);

  // Bits land at their frame position so the final bit can be checked in its own cycle.
  always_comb begin
    frame_nxt          = frame;
    frame_nxt[bit_cnt] = data_sync[1];
  end

`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = !frame_nxt[0] && frame_nxt[FRAME_BITS-1] && odd_parity_ok(frame_nxt[9:1]);
`else
  assign frame_ok = !frame_nxt[0] && frame_nxt[FRAME_BITS-1];
`endif

  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
      bit_cnt   <= 4'd0;
      frame     <= '0;
      to_cnt    <= 16'd0;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      if (fall) begin
        to_cnt  <= TIMEOUT_CYC - 16'd1;
        frame   <= frame_nxt;
        bit_cnt <= frame_end ? 4'd0 : bit_cnt + 4'd1;
      end else begin
        if (to_cnt != 16'd0) to_cnt <= to_cnt - 16'd1;
        if (timeout) begin
          bit_cnt <= 4'd0;
          frame   <= '0;
        end
      end
    end
  end

  assign fifo_push = frame_end && frame_ok;
  assign fifo_pop  = !fifo_empty;

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .clrn      (clrn),
    .push      (fifo_push),
    .push_data (frame_nxt[8:1]),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (!clrn) begin
      overflow_q <= 1'b0;
    end else if (fifo_push && fifo_full && !fifo_pop) begin
      overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) state_q <= DEC_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    make_evt = 1'b0;
    brk_evt  = 1'b0;
    if (fifo_pop) begin
      case (state_q)
        DEC_IDLE: begin
          if (fifo_head == BREAK_CODE)    state_d = DEC_BRK;
          else if (fifo_head == EXT_CODE) state_d = DEC_EXT;
          else                            make_evt = 1'b1;
        end
        DEC_EXT: begin
          if (fifo_head == BREAK_CODE) begin
            state_d = DEC_EXT_BRK;
          end else begin
            make_evt = 1'b1;
            state_d  = DEC_IDLE;
          end
        end
        DEC_BRK, DEC_EXT_BRK: begin
          brk_evt = 1'b1;
          state_d = DEC_IDLE;
        end
        default: state_d = DEC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      key_we_q    <= 1'b0;
      key_addr_q  <= 8'h00;
      key_code_q  <= 8'h00;
      key_down_q  <= 1'b0;
      last_code_q <= 8'h00;
    end else begin
      key_we_q <= make_evt;
      if (key_we_q) key_addr_q <= key_addr_q + 8'd1;
      if (make_evt) begin
        key_code_q  <= fifo_head;
        last_code_q <= fifo_head;
        key_down_q  <= 1'b1;
      end else if (brk_evt && (fifo_head == last_code_q)) begin
        key_down_q  <= 1'b0;
      end
    end
  end

  assign kif.key_we   = key_we_q;
  assign kif.key_addr = key_addr_q;
  assign kif.key_code = key_code_q;
  assign kif.key_down = key_down_q;
  assign kif.overflow = overflow_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Scoreboard bench for ps2_scan_rx: drives PS/2 frames, checks every key_we against expectations.
module tb_ps2_scan_rx;

  logic clk      = 1'b0;
  logic clrn     = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  ps2_scan_rx_if kif ();

  ps2_scan_rx #(
    .FIFO_DEPTH  (8),
    .TIMEOUT_CYC (16'd5000)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kif      (kif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] addr;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] exp_addr = 8'h00;
  int         checks   = 0;
  int         errors   = 0;
  int         cyc      = 0;
  int         stop_cyc = 0;
  int         we_lat   = 0;
  int         we_count = 0;
  int         base;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (kif.key_we === 1'b1) begin
      we_count++;
      we_lat = cyc - stop_cyc;
      if (sb_q.size() == 0) begin
        check_val("spurious_we", kif.key_we, 1'b0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("key_code", kif.key_code, mon_e.code);
        check_val("key_addr", kif.key_addr, mon_e.addr);
      end
    end
  end

  task automatic expect_make(input logic [7:0] code);
    sb_q.push_back({code, exp_addr});
    exp_addr = exp_addr + 8'd1;
  endtask

  task automatic send_bit(input logic b, input bit last);
    @(posedge clk); #1;
    ps2_data = b;
    repeat (2) @(posedge clk);
    #1 ps2_clk = 1'b0;
    if (last) stop_cyc = cyc;
    repeat (4) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_stop, input bit bad_par, input int nbits);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = code;
    f[9]   = (~^code) ^ bad_par;
    f[10]  = ~bad_stop;
    for (int i = 0; i < nbits; i++) send_bit(f[i], i == 10);
    repeat (4) @(posedge clk);
  endtask

  task automatic send_good(input logic [7:0] code);
    send_frame(code, 1'b0, 1'b0, 11);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clrn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_key_we", kif.key_we, 1'b0);
    check_val("rst_key_addr", kif.key_addr, 8'h00);
    check_val("rst_key_code", kif.key_code, 8'h00);
    check_val("rst_key_down", kif.key_down, 1'b0);
    check_val("rst_overflow", kif.overflow, 1'b0);
    sb_q.delete();
    exp_addr = 8'h00;
    @(posedge clk); #1;
    clrn = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic settle();
    repeat (20) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // single make, including stop-edge to key_we latency
    do_reset();
    base = we_count;
    expect_make(8'h1C);
    send_good(8'h1C);
    settle();
    check_val("t1_latency", we_lat, 4);
    check_val("t1_we_count", we_count - base, 1);
    check_val("t1_key_down", kif.key_down, 1'b1);
    check_val("t1_sb_empty", sb_q.size(), 0);

    // make then release
    do_reset();
    base = we_count;
    expect_make(8'h1C);
    send_good(8'h1C);
    send_good(8'hF0);
    send_good(8'h1C);
    settle();
    check_val("t2_we_count", we_count - base, 1);
    check_val("t2_key_addr", kif.key_addr, 8'h01);
    check_val("t2_key_down", kif.key_down, 1'b0);
    check_val("t2_sb_empty", sb_q.size(), 0);

    // extended make and extended release
    do_reset();
    base = we_count;
    expect_make(8'h75);
    send_good(8'hE0);
    send_good(8'h75);
    settle();
    check_val("t3_down_mid", kif.key_down, 1'b1);
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h75);
    settle();
    check_val("t3_we_count", we_count - base, 1);
    check_val("t3_key_down", kif.key_down, 1'b0);
    check_val("t3_sb_empty", sb_q.size(), 0);

    // decoder stalled: nine frames into an eight-entry FIFO
    do_reset();
    base = we_count;
    force dut.fifo_pop = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) expect_make(8'h15 + 8'(i));
      send_good(8'h15 + 8'(i));
    end
    settle();
    check_val("t4_overflow", kif.overflow, 1'b1);
    check_val("t4_we_stalled", we_count - base, 0);
    release dut.fifo_pop;
    settle();
    check_val("t4_we_count", we_count - base, 8);
    check_val("t4_key_addr", kif.key_addr, 8'h08);
    check_val("t4_overflow_sticky", kif.overflow, 1'b1);
    check_val("t4_sb_empty", sb_q.size(), 0);

    // bad stop bit, bad parity, then good frames
    do_reset();
    base = we_count;
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    settle();
    check_val("t5_bad_stop", we_count - base, 0);
    expect_make(8'h24);
    send_good(8'h24);
    settle();
    check_val("t5_after_stop", we_count - base, 1);
`ifndef PS2_PARITY_CHECK_EN
    expect_make(8'h2D);
`endif
    send_frame(8'h2D, 1'b0, 1'b1, 11);
    expect_make(8'h3C);
    send_good(8'h3C);
    settle();
`ifdef PS2_PARITY_CHECK_EN
    check_val("t5_we_count", we_count - base, 2);
`else
    check_val("t5_we_count", we_count - base, 3);
`endif
    check_val("t5_sb_empty", sb_q.size(), 0);

    // partial frame abandoned by timeout
    do_reset();
    base = we_count;
    send_frame(8'h11, 1'b0, 1'b0, 5);
    repeat (5010) @(posedge clk);
    expect_make(8'h2B);
    send_good(8'h2B);
    settle();
    check_val("t6_we_count", we_count - base, 1);
    check_val("t6_sb_empty", sb_q.size(), 0);

    // partial frame discarded by reset
    do_reset();
    send_frame(8'h11, 1'b0, 1'b0, 5);
    do_reset();
    base = we_count;
    expect_make(8'h33);
    send_good(8'h33);
    settle();
    check_val("t7_we_count", we_count - base, 1);
    check_val("t7_sb_empty", sb_q.size(), 0);

    // typematic repeats wrap the address
    do_reset();
    base = we_count;
    for (int i = 0; i < 256; i++) begin
      expect_make(8'h1C);
      send_good(8'h1C);
    end
    settle();
    check_val("t8_we_count", we_count - base, 256);
    check_val("t8_key_addr", kif.key_addr, 8'h00);
    check_val("t8_key_down", kif.key_down, 1'b1);
    check_val("t8_overflow", kif.overflow, 1'b0);
    check_val("t8_sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning scancode buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16'd5000, meaning idle clk cycles before a partial frame is abandoned.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic on posedge.
REQ-004 SHALL have port clrn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ps2_clk  input  1  raw keyboard clock, asynchronous.
REQ-006 SHALL have port ps2_data  input  1  raw keyboard data, asynchronous.
REQ-007 SHALL have port key_we  output  1  one-cycle write strobe to the scancode RAM stage.
REQ-008 SHALL have port key_addr  output  8  RAM write address for the current make code.
REQ-009 SHALL have port key_code  output  8  make scancode; valid while key_we=1.
REQ-010 SHALL have port key_down  output  1  high while the last make code is not yet released.
REQ-011 SHALL have port overflow  output  1  sticky; a frame was lost because the FIFO was full.

Function
REQ-012 SHALL pass ps2_clk through a 3-flop synchronizer; a falling edge is sync[2:1]==2'b10.
REQ-013 SHALL shift ps2_data into an 11-bit frame buffer on each detected falling edge, with bit counter 0..10.
REQ-014 SHALL, on the edge with counter==10, check start==0 and stop==1, then return the counter to 0 in every case.
REQ-015 SHALL push frame bits[8:1] into the FIFO on the cycle after a valid frame; invalid frames are dropped silently.
REQ-016 SHALL reject a push when the FIFO is full and no pop occurs that cycle, setting overflow; a simultaneous pop makes the push succeed.
REQ-017 SHALL clear the bit counter and frame buffer when counter!=0 and TIMEOUT_CYC cycles pass with no falling edge.
REQ-018 SHALL run a decoder FSM that pops one FIFO entry per cycle while the FIFO is non-empty.
REQ-019 SHALL use decoder states IDLE, BRK, EXT and EXT_BRK. IDLE: F0->BRK, E0->EXT, other->make. EXT: F0->EXT_BRK, other->make, IDLE. BRK and EXT_BRK: any code->release, IDLE.
REQ-020 SHALL, on a make, assert key_we for exactly one cycle on the cycle after the pop, drive key_code with the code and key_addr with the current address, and set key_down with last_code=code.
REQ-021 SHALL increment key_addr on the cycle after each key_we, wrapping 8'hFF->8'h00.
REQ-022 SHALL, on a release whose code equals last_code, clear key_down; other releases leave key_down unchanged.
REQ-023 SHALL produce key_we exactly 2 clk cycles after the cycle in which the stop-bit edge is detected, when the FIFO was empty.
REQ-024 SHALL generate a key_we for every typematic repeat of a make code.

Reset
REQ-025 SHALL, while clrn==0 at posedge clk, clear the synchronizer to 3'b111, the counter, the frame buffer, the timeout counter, the FIFO pointers, key_we, key_addr, key_code, key_down, last_code and overflow, and set the FSM to IDLE.
REQ-026 SHALL discard a frame that is partially received when reset is asserted; reception resumes at the next start bit.

Configuration
REQ-027 SHALL, when PS2_PARITY_CHECK_EN is defined, also require odd parity over bits[9:1] for a frame to be valid.
REQ-028 SHALL, when PS2_PARITY_CHECK_EN is undefined, ignore bit 9.

Structure
REQ-029 SHALL take constants BREAK_CODE=8'hF0, EXT_CODE=8'hE0, FRAME_BITS=11 and the decoder state enum from shared package ps2_pkg.
REQ-030 SHALL implement the buffer as sub-module ps2_fifo, a synchronous FIFO with push, pop, full, empty and head outputs.

Verification
REQ-031 SHALL cover: reset, then frame 0x1C (A) -> one key_we, key_code=8'h1C, key_addr=8'h00, key_down=1.
REQ-032 SHALL cover: 1C, F0, 1C -> one key_we, key_addr ends at 8'h01, key_down=0 after the release.
REQ-033 SHALL cover: E0, 75, E0, F0, 75 -> one key_we with code 8'h75 and no key_we for E0 or F0.
REQ-034 SHALL cover: FIFO_DEPTH+1 frames with the decoder stalled by forced full -> overflow=1 and the first 8 codes delivered in order.
REQ-035 SHALL cover: frame with a bad stop bit, or bad parity with PS2_PARITY_CHECK_EN -> no key_we and the next good frame is received.
REQ-036 SHALL cover: 256 makes -> key_addr wraps to 8'h00; 5 bits then a TIMEOUT_CYC gap then a full frame -> the frame is decoded correctly.
